// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - keypad digit accumulator and command-toggle initiator for the execution datapath
// Optional feature: define KEYPAD_BACKSPACE_EN to make key 15 a backspace.
module keypad_entry #(
  parameter int MAX_DIGITS  = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int MAX_QTY     = 99
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        key_ready,
  output logic [13:0] inNumbers,
  output logic        storeOut,
  output logic        updateOut,
  output logic        showOut,
  output logic        resetOut,
  output logic        errOut
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [3:0] KEY_CLEAR  = 4'd10;
  localparam logic [3:0] KEY_STORE  = 4'd11;
  localparam logic [3:0] KEY_UPDATE = 4'd12;
  localparam logic [3:0] KEY_SHOW   = 4'd13;
  localparam logic [3:0] KEY_ALL    = 4'd14;
`ifdef KEYPAD_BACKSPACE_EN
  localparam logic [3:0] KEY_BKSP   = 4'd15;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [13:0]   entry_q, entry_d;
  logic [CW-1:0] count_q, count_d;
  logic [HW-1:0] hold_q,  hold_d;
  logic          store_q, store_d;
  logic          update_q, update_d;
  logic          show_q, show_d;
  logic          rst_tog_q, rst_tog_d;
  logic          err_q, err_d;
  logic [13:0]   entry_x10;

  // x10 as x8 + x2; the digit limit keeps the result inside 14 bits
  assign entry_x10 = {entry_q[10:0], 3'b000} + {entry_q[12:0], 1'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      entry_q   <= '0;
      count_q   <= '0;
      hold_q    <= '0;
      store_q   <= 1'b0;
      update_q  <= 1'b0;
      show_q    <= 1'b0;
      rst_tog_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      entry_q   <= entry_d;
      count_q   <= count_d;
      hold_q    <= hold_d;
      store_q   <= store_d;
      update_q  <= update_d;
      show_q    <= show_d;
      rst_tog_q <= rst_tog_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    entry_d   = entry_q;
    count_d   = count_q;
    hold_d    = hold_q;
    store_d   = store_q;
    update_d  = update_q;
    show_d    = show_q;
    rst_tog_d = rst_tog_q;
    err_d     = err_q;

    if (state_q == S_HOLD) begin
      // entry stays on inNumbers until the datapath has had HOLD_CYCLES to sample it
      if (hold_q == '0) begin
        state_d = S_IDLE;
        entry_d = '0;
        count_d = '0;
      end else begin
        hold_d = hold_q - 1'b1;
      end
    end else if (key_valid) begin
      if (key_code == KEY_CLEAR) begin
        entry_d = '0;
        count_d = '0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end else if (key_code == KEY_ALL) begin
        rst_tog_d = ~rst_tog_q;
        entry_d   = '0;
        count_d   = '0;
        err_d     = 1'b0;
        hold_d    = HW'(HOLD_CYCLES - 1);
        state_d   = S_HOLD;
      end else if (state_q != S_ERR) begin
        if (key_code <= 4'd9) begin
          if (count_q == CW'(MAX_DIGITS)) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            entry_d = entry_x10 + {10'b0, key_code};
            count_d = count_q + 1'b1;
            state_d = S_ACCUM;
          end
        end else if (key_code == KEY_STORE) begin
          store_d = ~store_q;
          hold_d  = HW'(HOLD_CYCLES - 1);
          state_d = S_HOLD;
        end else if (key_code == KEY_SHOW) begin
          show_d  = ~show_q;
          hold_d  = HW'(HOLD_CYCLES - 1);
          state_d = S_HOLD;
        end else if (key_code == KEY_UPDATE) begin
          if (entry_q > 14'(MAX_QTY)) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            update_d = ~update_q;
            hold_d   = HW'(HOLD_CYCLES - 1);
            state_d  = S_HOLD;
          end
        end
`ifdef KEYPAD_BACKSPACE_EN
        else if (key_code == KEY_BKSP && state_q == S_ACCUM) begin
          entry_d = entry_q / 14'd10;
          count_d = count_q - 1'b1;
          state_d = (count_q == CW'(1)) ? S_IDLE : S_ACCUM;
        end
`endif
      end
    end
  end

  assign key_ready = (state_q != S_HOLD);
  assign inNumbers = entry_q;
  assign storeOut  = store_q;
  assign updateOut = update_q;
  assign showOut   = show_q;
  assign resetOut  = rst_tog_q;
  assign errOut    = err_q;

endmodule

// File: tb/tb_keypad_entry.sv
// tb/tb_keypad_entry.sv - vector table, corner sequences and randomized model check for keypad_entry
module tb_keypad_entry;

  localparam int MAXD = 4;
  localparam int HOLD = 2;
  localparam int MAXQ = 99;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic [13:0] inNumbers;
  logic        storeOut, updateOut, showOut, resetOut, errOut;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  keypad_entry #(.MAX_DIGITS(MAXD), .HOLD_CYCLES(HOLD), .MAX_QTY(MAXQ)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .inNumbers(inNumbers), .storeOut(storeOut),
    .updateOut(updateOut), .showOut(showOut), .resetOut(resetOut), .errOut(errOut)
  );

  // toggles packed as {store, update, show, reset}
  typedef struct {
    bit          rst;
    bit          kv;
    logic [3:0]  kc;
    logic [13:0] num;
    logic [3:0]  tog;
    bit          err;
    bit          rdy;
  } vec_t;

  vec_t vecs[$];

  int       m_entry, m_count, m_hold;
  bit       m_err;
  bit [3:0] m_tog;

  task automatic add(input bit r, input bit kv, input int kc, input int num,
                     input logic [3:0] tog, input bit err, input bit rdy);
    vec_t v;
    v.rst = r; v.kv = kv; v.kc = 4'(kc); v.num = 14'(num);
    v.tog = tog; v.err = err; v.rdy = rdy;
    vecs.push_back(v);
  endtask

  task automatic drive(input bit r, input bit kv, input logic [3:0] kc);
    reset = r; key_valid = kv; key_code = kc;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [13:0] num, input logic [3:0] tog,
                       input bit err, input bit rdy);
    logic [19:0] act, exp;
    act = {inNumbers, storeOut, updateOut, showOut, resetOut, errOut, key_ready};
    exp = {num, tog, err, rdy};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got num=%0d tog=%b err=%b rdy=%b, need num=%0d tog=%b err=%b rdy=%b",
               name, inNumbers, {storeOut, updateOut, showOut, resetOut}, errOut, key_ready,
               num, tog, err, rdy);
    end
  endtask

  // Behavioural model: one call per clock edge, working on plain integers
  task automatic model_step(input bit r, input bit kv, input int kc);
    if (r) begin
      m_entry = 0; m_count = 0; m_hold = 0; m_err = 0; m_tog = '0;
    end else if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) begin m_entry = 0; m_count = 0; end
    end else if (kv) begin
      if (kc == 10) begin
        m_entry = 0; m_count = 0; m_err = 0;
      end else if (kc == 14) begin
        m_tog[0] = ~m_tog[0]; m_entry = 0; m_count = 0; m_err = 0; m_hold = HOLD;
      end else if (!m_err) begin
        if (kc <= 9) begin
          if (m_count == MAXD) m_err = 1;
          else begin m_entry = m_entry * 10 + kc; m_count++; end
        end else if (kc == 11) begin
          m_tog[3] = ~m_tog[3]; m_hold = HOLD;
        end else if (kc == 13) begin
          m_tog[1] = ~m_tog[1]; m_hold = HOLD;
        end else if (kc == 12) begin
          if (m_entry > MAXQ) m_err = 1;
          else begin m_tog[2] = ~m_tog[2]; m_hold = HOLD; end
        end else if (kc == 15) begin
`ifdef KEYPAD_BACKSPACE_EN
          if (m_count > 0) begin m_entry = m_entry / 10; m_count--; end
`endif
        end
      end
    end
  endtask

  initial begin
    bit pend;
    bit kv;
    bit r;
    bit rdy_before;
    int kc;

    reset = 1'b1; key_valid = 1'b0; key_code = 4'd0;

    add(1,0,0,    0,4'b0000,0,1);
    add(0,1,1,    1,4'b0000,0,1);
    add(0,1,2,   12,4'b0000,0,1);
    add(0,1,5,  125,4'b0000,0,1);
    add(0,1,0, 1250,4'b0000,0,1);
    add(0,1,11,1250,4'b1000,0,0);
    add(0,0,0, 1250,4'b1000,0,0);
    add(0,0,0,    0,4'b1000,0,1);
    add(0,1,1,    1,4'b1000,0,1);
    add(0,1,0,   10,4'b1000,0,1);
    add(0,1,0,  100,4'b1000,0,1);
    add(0,1,0, 1000,4'b1000,0,1);
    add(0,1,1, 1000,4'b1000,1,1);
    add(0,1,3, 1000,4'b1000,1,1);
    add(0,1,10,   0,4'b1000,0,1);
    add(0,1,2,    2,4'b1000,0,1);
    add(0,1,12,   2,4'b1100,0,0);
    add(0,0,0,    2,4'b1100,0,0);
    add(0,0,0,    0,4'b1100,0,1);
    add(0,1,1,    1,4'b1100,0,1);
    add(0,1,0,   10,4'b1100,0,1);
    add(0,1,0,  100,4'b1100,0,1);
    add(0,1,12, 100,4'b1100,1,1);
    add(0,1,10,   0,4'b1100,0,1);
    add(0,1,0,    0,4'b1100,0,1);
    add(0,1,0,    0,4'b1100,0,1);
    add(0,1,0,    0,4'b1100,0,1);
    add(0,1,0,    0,4'b1100,0,1);
    add(0,1,5,    0,4'b1100,1,1);
    add(0,1,14,   0,4'b1101,0,0);
    add(0,0,0,    0,4'b1101,0,0);
    add(0,0,0,    0,4'b1101,0,1);
    add(0,1,7,    7,4'b1101,0,1);
    add(0,1,10,   0,4'b1101,0,1);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].kv, vecs[i].kc);
      check($sformatf("vec%0d", i), vecs[i].num, vecs[i].tog, vecs[i].err, vecs[i].rdy);
    end

    // show twice, second key held through HOLD
    drive(0,1,4'd13); check("show1",       0, 4'b1111, 0, 0);
    drive(0,1,4'd13); check("show_hold",   0, 4'b1111, 0, 0);
    drive(0,1,4'd13); check("show_rdy",    0, 4'b1111, 0, 1);
    drive(0,1,4'd13); check("show2",       0, 4'b1101, 0, 0);
    drive(0,0,4'd0);  check("show2_hold",  0, 4'b1101, 0, 0);
    drive(0,0,4'd0);  check("show2_done",  0, 4'b1101, 0, 1);

    // reset together with all-clear
    drive(0,1,4'd4);  check("rc_4",        4, 4'b1101, 0, 1);
    drive(0,1,4'd2);  check("rc_42",      42, 4'b1101, 0, 1);
    drive(1,1,4'd14); check("rc_reset",    0, 4'b0000, 0, 1);
    drive(0,0,4'd0);  check("rc_after",    0, 4'b0000, 0, 1);

    // reset mid-hold
    drive(0,1,4'd3);  check("rh_3",        3, 4'b0000, 0, 1);
    drive(0,1,4'd11); check("rh_store",    3, 4'b1000, 0, 0);
    drive(1,0,4'd0);  check("rh_reset",    0, 4'b0000, 0, 1);

`ifdef KEYPAD_BACKSPACE_EN
    drive(0,1,4'd9);  check("bs_9",        9, 4'b0000, 0, 1);
    drive(0,1,4'd8);  check("bs_98",      98, 4'b0000, 0, 1);
    drive(0,1,4'd7);  check("bs_987",    987, 4'b0000, 0, 1);
    drive(0,1,4'd15); check("bs_98b",     98, 4'b0000, 0, 1);
    drive(0,1,4'd15); check("bs_9b",       9, 4'b0000, 0, 1);
    drive(0,1,4'd15); check("bs_0",        0, 4'b0000, 0, 1);
    drive(0,1,4'd15); check("bs_idle",     0, 4'b0000, 0, 1);
    drive(0,1,4'd6);  check("bs_6",        6, 4'b0000, 0, 1);
`else
    drive(0,1,4'd9);  check("nobs_9",      9, 4'b0000, 0, 1);
    drive(0,1,4'd15); check("nobs_15",     9, 4'b0000, 0, 1);
`endif
    drive(0,1,4'd10); check("pre_rand",    0, 4'b0000, 0, 1);

    // randomized run against the model
    drive(1,0,4'd0);
    model_step(1,0,0);
    check("rand_reset", 14'(m_entry), m_tog, m_err, m_hold == 0);
    pend = 0; kv = 0; kc = 0;
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0,199) == 0);
      if (!pend) begin
        kv = ($urandom_range(0,3) != 0);
        kc = ($urandom_range(0,99) < 65) ? int'($urandom_range(0,9)) : int'($urandom_range(10,15));
      end
      rdy_before = (m_hold == 0);
      drive(r, kv, 4'(kc));
      model_step(r, kv, kc);
      pend = !r && kv && !rdy_before;
      check($sformatf("rand%0d", i), 14'(m_entry), m_tog, m_err, m_hold == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
